// File: rtl/mtm_alu_cmd_serializer_pkg.sv
// Shared types, constants and helpers for the mtm_Alu command serializer.
package mtm_alu_cmd_serializer_pkg;

    typedef enum logic [2:0] {
        OpAnd = 3'b000,
        OpOr  = 3'b001,
        OpAdd = 3'b100,
        OpSub = 3'b101
    } op_t;

    localparam logic [2:0] OP_INVALID = 3'b010;

    // Frame type bit
    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CTL  = 1'b1;

    // Bit positions inside the error-injection flags
    localparam int unsigned ERR_DATA = 0;
    localparam int unsigned ERR_CRC  = 1;
    localparam int unsigned ERR_OP   = 2;

    // Widest CRC input: two 64-bit operands plus the 1'b1 marker and op
    localparam int unsigned CRC_MAX_BITS = 132;

    // CRC4 x^4+x+1, init 0, over the low nbits of 'bits', MSB first
    function automatic logic [3:0] crc4_calc(input logic [CRC_MAX_BITS-1:0] bits,
                                             input int unsigned nbits);
        logic [3:0] crc;
        logic       fb;
        crc = 4'h0;
        for (int i = 0; i < CRC_MAX_BITS; i++) begin
            if ((CRC_MAX_BITS - 1 - i) < nbits) begin
                fb  = crc[3] ^ bits[8'(CRC_MAX_BITS - 1 - i)];
                crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
            end
        end
        return crc;
    endfunction

    // One step of the Fibonacci LFSR x^32+x^22+x^2+x+1
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

endpackage

// File: rtl/mtm_alu_frame_tx.sv
// 11-bit serial frame shifter: start 0, type, payload MSB first, stop 1.
module mtm_alu_frame_tx
    import mtm_alu_cmd_serializer_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       type_i,
    input  logic [7:0] payload_i,
    output logic       sin_o,
    output logic       frame_done_o,
    output logic       frame_last_o
);

    logic [10:0] shreg_q, shreg_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        active_q, active_d;

    // Shift one bit per cycle; a load (even during a stop bit) restarts the frame
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        active_d  = active_q;
        if (active_q) begin
            shreg_d   = {shreg_q[9:0], 1'b1};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd10) begin
                active_d = 1'b0;
            end
        end
        if (load_i) begin
            shreg_d   = {1'b0, type_i, payload_i, 1'b1};
            bit_cnt_d = 4'd0;
            active_d  = 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q   <= '1;
            bit_cnt_q <= 4'd0;
            active_q  <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            active_q  <= active_d;
        end
    end

    // Line idles high whenever no frame is active, so reset forces it high at once
    assign sin_o        = active_q ? shreg_q[10] : 1'b1;
    assign frame_done_o = active_q && (bit_cnt_q == 4'd10);
    assign frame_last_o = active_q && (bit_cnt_q == 4'd9);

endmodule

// File: rtl/mtm_alu_cmd_serializer.sv
// Command serializer for the mtm_Alu serial input: frames B, A and a ctl frame with CRC4.
// Optional LFSR self-stimulus is enabled by defining MTM_ALU_SER_LFSR_EN.
module mtm_alu_cmd_serializer
    import mtm_alu_cmd_serializer_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned GAP_BITS  = 2,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [DATA_W-1:0] cmd_b_i,
    input  logic [DATA_W-1:0] cmd_a_i,
    input  logic [2:0]        cmd_op_i,
    input  logic [2:0]        cmd_err_i,
    input  logic              rand_en_i,
    output logic              sin_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       cmd_cnt_o
);

    localparam int unsigned NB       = DATA_W / 8;
    localparam int unsigned WORD_W   = 2 * DATA_W;
    localparam int unsigned CRC_BITS = WORD_W + 4;
    // GAP lasts GAP_BITS-1 cycles; the final idle bit-time is spent in IDLE
    localparam int unsigned GAP_LAST = (GAP_BITS >= 2) ? GAP_BITS - 2 : 0;

    typedef enum logic [1:0] {StIdle, StData, StCtl, StGap} state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d, word_sh;
    logic [7:0]          ctl_q, ctl_d;
    logic                err_data_q, err_data_d;
    logic [3:0]          byte_cnt_q, byte_cnt_d, last_byte;
    logic [15:0]         gap_cnt_q, gap_cnt_d;
    logic [15:0]         cmd_cnt_q, cmd_cnt_d;
    logic                done_q, done_d;

    logic                issue;
    logic [DATA_W-1:0]   src_b, src_a;
    logic [2:0]          src_op, src_err, op_eff;
    logic [3:0]          crc_tx;

    logic                load, ld_type, frame_done, frame_last;
    logic [7:0]          ld_payload;

`ifdef MTM_ALU_SER_LFSR_EN
    logic [31:0] lfsr_q, lfsr_d, lfsr_s1, lfsr_s2;
    logic        self_issue;

    // Command source: cmd_valid wins; otherwise rand_en self-issues from the LFSR
    always_comb begin
        lfsr_s1    = lfsr_step(lfsr_q);
        lfsr_s2    = lfsr_step(lfsr_s1);
        self_issue = (state_q == StIdle) && rand_en_i && !cmd_valid_i;
        issue      = (state_q == StIdle) && (cmd_valid_i || rand_en_i);
        lfsr_d     = self_issue ? lfsr_s2 : lfsr_q;
        src_b      = cmd_b_i;
        src_a      = cmd_a_i;
        src_op     = cmd_op_i;
        src_err    = cmd_err_i;
        if (self_issue) begin
            src_b   = DATA_W'(lfsr_s1);
            src_a   = DATA_W'(lfsr_s2);
            src_err = 3'b000;
            unique case (lfsr_s2[1:0])
                2'b00:   src_op = OpAnd;
                2'b01:   src_op = OpOr;
                2'b10:   src_op = OpAdd;
                default: src_op = OpSub;
            endcase
        end
    end

    // LFSR register, advanced only on self-issued commands
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end
`else
    logic unused_rand_en;
    assign unused_rand_en = rand_en_i;
    assign issue          = (state_q == StIdle) && cmd_valid_i;
    assign src_b          = cmd_b_i;
    assign src_a          = cmd_a_i;
    assign src_op         = cmd_op_i;
    assign src_err        = cmd_err_i;
`endif

    // Op substitution feeds both the ctl frame and the CRC; CRC flip comes after
    always_comb begin
        op_eff = src_err[ERR_OP] ? OP_INVALID : src_op;
        crc_tx = crc4_calc(CRC_MAX_BITS'({src_b, src_a, 1'b1, op_eff}), CRC_BITS)
                 ^ (src_err[ERR_CRC] ? 4'hF : 4'h0);
    end

    // Next-state, frame loading and completion bookkeeping
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        ctl_d      = ctl_q;
        err_data_d = err_data_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        cmd_cnt_d  = cmd_cnt_q;
        done_d     = 1'b0;
        load       = 1'b0;
        ld_type    = FRAME_DATA;
        ld_payload = 8'h00;
        last_byte  = err_data_q ? 4'(2 * NB - 2) : 4'(2 * NB - 1);
        word_sh    = word_q << {byte_cnt_q + 4'd1, 3'b000};
        case (state_q)
            StIdle: begin
                if (issue) begin
                    word_d     = {src_b, src_a};
                    ctl_d      = {1'b0, op_eff, crc_tx};
                    err_data_d = src_err[ERR_DATA];
                    byte_cnt_d = 4'd0;
                    load       = 1'b1;
                    ld_payload = src_b[DATA_W-1 -: 8];
                    state_d    = StData;
                end
            end
            StData: begin
                if (frame_done) begin
                    load       = 1'b1;
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_q == last_byte) begin
                        ld_type    = FRAME_CTL;
                        ld_payload = ctl_q;
                        state_d    = StCtl;
                    end else begin
                        ld_payload = word_sh[WORD_W-1 -: 8];
                    end
                end
            end
            StCtl: begin
                // Without a gap, IDLE overlaps the ctl stop bit so commands abut
                if (GAP_BITS == 0) begin
                    if (frame_last) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        cmd_cnt_d = cmd_cnt_q + 16'd1;
                    end
                end else if (frame_done) begin
                    if (GAP_BITS == 1) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        cmd_cnt_d = cmd_cnt_q + 16'd1;
                    end else begin
                        state_d   = StGap;
                        gap_cnt_d = 16'd0;
                    end
                end
            end
            StGap: begin
                if (gap_cnt_q == 16'(GAP_LAST)) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    cmd_cnt_d = cmd_cnt_q + 16'd1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            word_q     <= '0;
            ctl_q      <= 8'h00;
            err_data_q <= 1'b0;
            byte_cnt_q <= 4'd0;
            gap_cnt_q  <= 16'd0;
            cmd_cnt_q  <= 16'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            ctl_q      <= ctl_d;
            err_data_q <= err_data_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            cmd_cnt_q  <= cmd_cnt_d;
            done_q     <= done_d;
        end
    end

    mtm_alu_frame_tx u_frame_tx (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_i       (load),
        .type_i       (ld_type),
        .payload_i    (ld_payload),
        .sin_o        (sin_o),
        .frame_done_o (frame_done),
        .frame_last_o (frame_last)
    );

    assign cmd_ready_o = (state_q == StIdle);
    // The final bit-time runs in IDLE with done high; it still belongs to the command
    assign busy_o      = (state_q != StIdle) || done_q;
    assign done_o      = done_q;
    assign cmd_cnt_o   = cmd_cnt_q;

endmodule
